// File: rtl/beat_int_sequencer.sv
// One-hot W-beat sequencer with STP halt/resume and a prioritised, maskable,
// vectored interrupt-entry stage with optional wake from halt.

module beat_int_irq_cell (
  input  logic clk,
  input  logic clr,
  input  logic irq_i,
  input  logic take_i,
  output logic pend_o
);
  logic prev_q, pend_q;

  // A new rising edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= irq_i;
      pend_q <= (irq_i & ~prev_q) | (pend_q & ~take_i);
    end
  end

  assign pend_o = pend_q;
endmodule

module beat_int_sequencer #(
  parameter int NUM_IRQ     = 4,
  parameter int MAX_W       = 4,
  parameter int VEC_W       = 8,
  parameter int VEC_BASE    = 'hE0,
  parameter int VEC_STRIDE  = 4,
  parameter int WAKE_ON_IRQ = 1,
  localparam int IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               go_i,
  input  logic               end_i,
  input  logic               stop_i,
  input  logic               iret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  output logic [MAX_W-1:0]   w_o,
  output logic               halted_o,
  output logic               int_stage_o,
  output logic [IDW-1:0]     int_id_o,
  output logic [VEC_W-1:0]   int_vec_o,
  output logic               en_int_o,
  output logic [NUM_IRQ-1:0] pending_o
);
  localparam logic [MAX_W-1:0] W1 = MAX_W'(1);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t             state_q;
  logic [MAX_W-1:0]   w_q, resume_q, w_nxt;
  logic               int_stage_q, en_int_q;
  logic [IDW-1:0]     int_id_q, sel_id;
  logic [NUM_IRQ-1:0] pend, req, take;
  logic               boundary, run_acc, wake_acc, accept;
  logic [31:0]        vec_full;

  genvar k;
  generate
    for (k = 0; k < NUM_IRQ; k++) begin : g_irq
      assign take[k] = accept && (sel_id == IDW'(k));
      beat_int_irq_cell u_cell (
        .clk    (clk),
        .clr    (clr),
        .irq_i  (irq_i[k]),
        .take_i (take[k]),
        .pend_o (pend[k])
      );
    end
  endgenerate

  assign req = pend & ~irq_mask_i;

  // Downward scan so the lowest-index request is the last to assign.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req[i]) sel_id = IDW'(i);
  end

  // The W_MAX forced wrap is an instruction boundary just like end_i.
  assign boundary = end_i | w_q[MAX_W-1];
  assign w_nxt    = boundary ? W1 : {w_q[MAX_W-2:0], 1'b0};
  assign run_acc  = (state_q == S_RUN) && boundary && !int_stage_q && en_int_q && (|req);
  assign wake_acc = (WAKE_ON_IRQ != 0) && (state_q == S_HALT) && en_int_q && (|req);
  assign accept   = run_acc | wake_acc;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_HALT;
      w_q         <= '0;
      resume_q    <= W1;
      int_stage_q <= 1'b0;
      int_id_q    <= '0;
      en_int_q    <= 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          w_q <= w_nxt;
          if (boundary) begin
            int_stage_q <= 1'b0;
            if (iret_i) en_int_q <= 1'b1;
          end
          if (run_acc) begin
            int_stage_q <= 1'b1;
            int_id_q    <= sel_id;
            en_int_q    <= 1'b0;
          end
          if (stop_i) begin
            state_q  <= S_HALT;
            w_q      <= '0;
            resume_q <= w_nxt;
          end
        end
        S_HALT: begin
          // Wake-up takes precedence over a simultaneous go_i.
          if (wake_acc) begin
            state_q     <= S_RUN;
            w_q         <= W1;
            int_stage_q <= 1'b1;
            int_id_q    <= sel_id;
            en_int_q    <= 1'b0;
          end else if (go_i) begin
            state_q <= S_RUN;
            w_q     <= resume_q;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign vec_full    = 32'(VEC_BASE) + 32'(int_id_q) * 32'(VEC_STRIDE);
  assign int_vec_o   = vec_full[VEC_W-1:0];
  assign w_o         = w_q;
  assign halted_o    = (state_q == S_HALT);
  assign int_stage_o = int_stage_q;
  assign int_id_o    = int_id_q;
  assign en_int_o    = en_int_q;
  assign pending_o   = pend;
endmodule

// File: doc/beat_int_sequencer.md
Name: beat_int_sequencer

Overview:
Parametrised beat generator and vectored interrupt sequencer for the hardwired controller. It produces the one-hot W-beat timing (W1..W_MAX) with decoder-controlled instruction length, handles STP halt/resume, and replaces the single-source ST1 interrupt stage with NUM_IRQ prioritised, maskable sources that deliver a vector address. The decode logic consumes w, int_stage and int_vec; this block consumes end-of-instruction, stop and iret indications from the decode logic.

Parameters:
NUM_IRQ, 4, number of interrupt sources (1..8)
MAX_W, 4, number of beats; the beat counter forcibly wraps after W_MAX
VEC_W, 8, vector address width
VEC_BASE, 8'hE0, vector of source 0
VEC_STRIDE, 4, vector spacing between sources
WAKE_ON_IRQ, 1, 1 = an accepted interrupt ends the halted state

Ports:
clk  in  1  beat clock; all state updates on rising edge
clr  in  1  reset, asynchronous, active-low
go_i  in  1  console start/resume pulse, one cycle
end_i  in  1  current beat is the last beat of the instruction (decoder)
stop_i  in  1  halt after the current beat (decoder STP / console stop)
iret_i  in  1  current instruction is IRET (qualified internally by end_i)
irq_i  in  NUM_IRQ  interrupt requests, rising-edge sensitive, clk-synchronous
irq_mask_i  in  NUM_IRQ  1 = source masked
w_o  out  MAX_W  one-hot beat; all-zero while halted
halted_o  out  1  sequencer halted
int_stage_o  out  1  current instruction is the interrupt-entry stage (old ST1)
int_id_o  out  clog2(NUM_IRQ), min 1  id of the source being serviced
int_vec_o  out  VEC_W  VEC_BASE + int_id_o*VEC_STRIDE, modulo 2^VEC_W
en_int_o  out  1  interrupt enable flag
pending_o  out  NUM_IRQ  latched pending requests

Behaviour:
- Reset (clr low, async): halted_o=1, w_o=0, int_stage_o=0, int_id_o=0, en_int_o=1, pending_o=0, irq edge-history=0.
- Halted: go_i=1 -> next cycle halted_o=0, w_o=resume beat (W1 after reset or after a stop in a last beat; otherwise the beat following the stop beat). go_i while running is ignored.
- Running: each clk, beat n advances to n+1. Return to W1 if end_i=1 or n=MAX_W; the forced wrap at W_MAX also counts as an instruction boundary.
- stop_i=1 in any running beat: next cycle halted_o=1, w_o=0, resume beat recorded. stop_i and end_i together: the boundary actions (interrupt accept, iret) still occur in that same cycle.
- Edge detect: pending[k] set when irq_i[k]=1 and the previous sample was 0. Sampling continues while halted. A set and a clear of the same bit in the same cycle leave it set. Masked sources still latch pending.
- Accept condition, evaluated at the instruction boundary (end_i or W_MAX wrap) while running and int_stage_o=0: en_int_o=1 and (pending & ~mask)!=0. Priority: lowest index wins.
- On accept (next cycle): int_stage_o=1, int_id_o=id, pending[id] cleared, en_int_o=0, beat=W1.
- Interrupt stage: ends at its own boundary, after which int_stage_o=0. int_id_o and int_vec_o hold until the next accept. No nested accept can occur, because en_int_o=0.
- IRET: at a boundary with iret_i=1, en_int_o=1 next cycle. An interrupt pending at that boundary is not accepted until the next boundary, because the accept condition uses the pre-update en_int.
- Halted with WAKE_ON_IRQ=1: if en_int_o=1 and an unmasked request is pending, the next cycle gives halted_o=0, accept as above, and w_o=W1. With WAKE_ON_IRQ=0, requests stay pending until go_i.
- go_i and a wake-up in the same cycle: the wake-up (accept) takes effect.
- clr mid-instruction aborts immediately to reset values, including pending.

Test Plan:
- Reset, then go_i: w_o sequence 0001, 0010, 0100 (end_i in W3), 0001; halted_o 1 -> 0.
- end_i held 0: w_o reaches 1000, then wraps to 0001; a pending irq is accepted at that wrap.
- irq_i=0101, mask=0000, boundary reached: int_id_o=0, int_vec_o=E0, pending_o=0100, en_int_o=0. After iret_i+end_i, the next boundary gives int_id_o=2, int_vec_o=E8.
- mask=0001 with irq_i[0] edge: no accept, pending_o=0001 retained. Clearing the mask gives accept at the next boundary.
- stop_i in W2 (no end_i): halted, w_o=0. go_i resumes at W3.
- Halted, WAKE_ON_IRQ=1, irq_i[3] edge: halted_o 0, int_stage_o 1, int_vec_o=EC, w_o=0001. The same stimulus with WAKE_ON_IRQ=0 leaves the block halted with pending_o=1000.
